// File: rtl/miner_pkg.sv
// Shared types and constants for the SHA nonce-search round scheduler.
package miner_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ROUNDS = 3'd2,
        ADD    = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5
    } sched_state_e;

    localparam int NUM_ROUNDS       = 64;
    localparam int ROUND_IDX_W      = 6;
    localparam int CYCLES_PER_NONCE = 67;
    // One extra bit so the round count of 64 itself is representable.
    localparam int CNT_W            = 7;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Modulo-rollover_val counter; rollover_flag marks the final count before it wraps to zero.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = {NUM_CNT_BITS{1'b0}};
    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;
    logic                    last_s;

    assign last_s = (count_q == (rollover_val - CNT_ONE));

    // Next count: clear dominates, otherwise step and wrap after the last count.
    always_comb begin
        count_d       = count_q;
        rollover_flag = 1'b0;
        if (clear) begin
            count_d = CNT_ZERO;
        end else if (count_enable) begin
            rollover_flag = last_s;
            count_d       = last_s ? CNT_ZERO : (count_q + CNT_ONE);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/sha_round_sched.sv
// Nonce-search scheduler: sequences load / 64 rounds / add / check per nonce over a range.
// Optional hash_count statistics output enabled by defining SHA_SCHED_STATS_EN.
module sha_round_sched
    import miner_pkg::*;
#(
    parameter int NONCE_W = 32
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NONCE_W-1:0]     nonce_start,
    input  logic [NONCE_W-1:0]     nonce_end,
    input  logic                   hit,
    output logic                   load_en,
    output logic                   round_en,
    output logic [ROUND_IDX_W-1:0] round_idx,
    output logic                   add_en,
    output logic [NONCE_W-1:0]     nonce,
    output logic                   busy,
    output logic                   found,
    output logic                   exhausted
`ifdef SHA_SCHED_STATS_EN
    ,
    output logic [31:0]            hash_count
`endif
);

    localparam logic [CNT_W-1:0]   ROUND_ROLL_VAL = CNT_W'(NUM_ROUNDS);
    localparam logic [NONCE_W-1:0] NONCE_ONE      = {{(NONCE_W-1){1'b0}}, 1'b1};

    sched_state_e        state_q, state_d;
    logic [NONCE_W-1:0]  nonce_q, nonce_d;
    logic [NONCE_W-1:0]  end_q, end_d;
    logic                found_q, found_d;
    logic                exh_q, exh_d;
    logic                load_q, load_d;
    logic                round_q, round_d;
    logic                add_q, add_d;
    logic                busy_q, busy_d;
`ifdef SHA_SCHED_STATS_EN
    logic [31:0]         hash_q, hash_d;
`endif

    logic                abort_act_s;
    logic                cnt_clear_s;
    logic                cnt_en_s;
    logic                roll_s;
    logic [CNT_W-1:0]    cnt_s;

    assign abort_act_s = abort && (state_q != IDLE) && (state_q != DONE);
    assign cnt_clear_s = (state_q == LOAD) || abort_act_s;
    assign cnt_en_s    = (state_q == ROUNDS);

    flex_counter #(
        .NUM_CNT_BITS (CNT_W)
    ) u_round_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (cnt_clear_s),
        .count_enable  (cnt_en_s),
        .rollover_val  (ROUND_ROLL_VAL),
        .count_out     (cnt_s),
        .rollover_flag (roll_s)
    );

    // Next-state, range/flag updates, and enables decoded from the next state.
    always_comb begin
        state_d = state_q;
        nonce_d = nonce_q;
        end_d   = end_q;
        found_d = found_q;
        exh_d   = exh_q;
`ifdef SHA_SCHED_STATS_EN
        hash_d  = hash_q;
`endif
        if (abort_act_s) begin
            // Abort beats a simultaneous hit in CHECK, so flags and the count stay untouched.
            state_d = IDLE;
            found_d = 1'b0;
            exh_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = LOAD;
                        nonce_d = nonce_start;
                        end_d   = nonce_end;
                        found_d = 1'b0;
                        exh_d   = 1'b0;
`ifdef SHA_SCHED_STATS_EN
                        hash_d  = 32'd0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
                LOAD:   state_d = ROUNDS;
                ROUNDS: state_d = roll_s ? ADD : ROUNDS;
                ADD:    state_d = CHECK;
                CHECK: begin
`ifdef SHA_SCHED_STATS_EN
                    hash_d = sat_inc32(hash_q);
`endif
                    if (hit) begin
                        found_d = 1'b1;
                        state_d = DONE;
                    end else if (nonce_q == end_q) begin
                        exh_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        nonce_d = nonce_q + NONCE_ONE;
                        state_d = LOAD;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        load_d  = (state_d == LOAD);
        round_d = (state_d == ROUNDS);
        add_d   = (state_d == ADD);
        busy_d  = (state_d != IDLE) && (state_d != DONE);
    end

    // State, nonce range, flags and registered enables.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            nonce_q <= {NONCE_W{1'b0}};
            end_q   <= {NONCE_W{1'b0}};
            found_q <= 1'b0;
            exh_q   <= 1'b0;
            load_q  <= 1'b0;
            round_q <= 1'b0;
            add_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SHA_SCHED_STATS_EN
            hash_q  <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            nonce_q <= nonce_d;
            end_q   <= end_d;
            found_q <= found_d;
            exh_q   <= exh_d;
            load_q  <= load_d;
            round_q <= round_d;
            add_q   <= add_d;
            busy_q  <= busy_d;
`ifdef SHA_SCHED_STATS_EN
            hash_q  <= hash_d;
`endif
        end
    end

    assign load_en   = load_q;
    assign round_en  = round_q;
    assign add_en    = add_q;
    assign nonce     = nonce_q;
    assign busy      = busy_q;
    assign found     = found_q;
    assign exhausted = exh_q;
    assign round_idx = ((state_q == ROUNDS) && !cnt_s[CNT_W-1]) ?
                       cnt_s[ROUND_IDX_W-1:0] : {ROUND_IDX_W{1'b0}};
`ifdef SHA_SCHED_STATS_EN
    assign hash_count = hash_q;
`endif

endmodule

// File: tb/tb_sha_round_sched.sv
// Directed, table-driven bench for sha_round_sched plus hand-written abort/reset/stats sequences.
module tb_sha_round_sched;
    import miner_pkg::*;

    localparam int MAX_CYC = 400;

    logic        clk = 1'b0;
    logic        n_rst, start, abort, hit;
    logic [31:0] nonce_start, nonce_end;
    logic        load_en, round_en, add_en, busy, found, exhausted;
    logic [5:0]  round_idx;
    logic [31:0] nonce;
`ifdef SHA_SCHED_STATS_EN
    logic [31:0] hash_count;
`endif

    sha_round_sched #(.NONCE_W(32)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .abort       (abort),
        .nonce_start (nonce_start),
        .nonce_end   (nonce_end),
        .hit         (hit),
        .load_en     (load_en),
        .round_en    (round_en),
        .round_idx   (round_idx),
        .add_en      (add_en),
        .nonce       (nonce),
        .busy        (busy),
        .found       (found),
        .exhausted   (exhausted)
`ifdef SHA_SCHED_STATS_EN
        ,
        .hash_count  (hash_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int g_loads, g_rounds, g_adds, g_cycles, g_seq_err, g_idx_err, g_excl_err, g_gap_err;
    bit g_timeout;

    typedef struct {
        logic [31:0] ns;
        logic [31:0] ne;
        bit          hit_en;
        logic [31:0] hn;
        bit          abort_chk;
        bit          f;
        bit          e;
        logic [31:0] n;
        int          loads;
        int          cycles;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Runs one job from IDLE (entered at a negedge), supplying hit/abort in CHECK.
    task automatic run_job(input logic [31:0] ns, input logic [31:0] ne, input bit hit_en,
                           input logic [31:0] hn, input bit abort_chk);
        int          exp_idx;
        int          last_load;
        bit          add_prev;
        logic [31:0] exp_n;
        g_loads = 0; g_rounds = 0; g_adds = 0; g_cycles = -1;
        g_seq_err = 0; g_idx_err = 0; g_excl_err = 0; g_gap_err = 0;
        nonce_start = ns; nonce_end = ne; start = 1'b1; hit = 1'b0; abort = 1'b0;
        @(negedge clk);
        start = 1'b0; nonce_start = ~ns; nonce_end = ~ne;
        check("flags cleared on start", {62'd0, found, exhausted}, 64'd0);
        add_prev = 1'b0; exp_idx = 0; last_load = -1; exp_n = ns;
        g_timeout = 1'b1;
        for (int cyc = 1; cyc <= MAX_CYC; cyc++) begin
            if (found || exhausted || !busy) begin
                g_cycles  = cyc - 1;
                g_timeout = 1'b0;
                break;
            end
            if (int'(load_en) + int'(round_en) + int'(add_en) > 1) g_excl_err++;
            if (load_en) begin
                if (nonce !== exp_n) g_seq_err++;
                exp_n = exp_n + 32'd1;
                if (last_load >= 0 && (cyc - last_load) != CYCLES_PER_NONCE) g_gap_err++;
                last_load = cyc;
                g_loads++;
                exp_idx = 0;
            end
            if (round_en) begin
                if (round_idx !== exp_idx[5:0]) g_idx_err++;
                exp_idx++;
                g_rounds++;
            end else if (round_idx !== 6'd0) begin
                g_idx_err++;
            end
            if (add_en) g_adds++;
            hit      = add_prev && hit_en && (nonce == hn);
            abort    = add_prev && abort_chk;
            start    = ((cyc % 7) == 3);
            add_prev = add_en;
            @(negedge clk);
        end
        hit = 1'b0; abort = 1'b0; start = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0010, 32'h0000_0010, 1'b1, 32'h0000_0010, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 1, 67};
        vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0007, 3, 201};
        vecs[2] = '{32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0001, 4, 268};
        vecs[3] = '{32'h0000_0064, 32'h0000_0067, 1'b1, 32'h0000_0066, 1'b0, 1'b1, 1'b0, 32'h0000_0066, 3, 201};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1, 67};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1, 67};
        vecs[6] = '{32'h0000_0040, 32'h0000_0045, 1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 1, 67};

        n_rst = 1'b0; start = 1'b0; abort = 1'b0; hit = 1'b0;
        nonce_start = 32'h1234_5678; nonce_end = 32'h9ABC_DEF0;
        repeat (2) @(negedge clk);
        check("reset enables", {61'd0, load_en, round_en, add_en}, 64'd0);
        check("reset round_idx", {58'd0, round_idx}, 64'd0);
        check("reset nonce", {32'd0, nonce}, 64'd0);
        check("reset flags", {61'd0, busy, found, exhausted}, 64'd0);
        n_rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i].ns, vecs[i].ne, vecs[i].hit_en, vecs[i].hn, vecs[i].abort_chk);
            check($sformatf("v%0d timeout", i), {63'd0, g_timeout}, 64'd0);
            check($sformatf("v%0d found", i), {63'd0, found}, {63'd0, vecs[i].f});
            check($sformatf("v%0d exhausted", i), {63'd0, exhausted}, {63'd0, vecs[i].e});
            check($sformatf("v%0d nonce", i), {32'd0, nonce}, {32'd0, vecs[i].n});
            check($sformatf("v%0d load pulses", i), 64'(g_loads), 64'(vecs[i].loads));
            check($sformatf("v%0d round cycles", i), 64'(g_rounds), 64'(64 * vecs[i].loads));
            check($sformatf("v%0d add pulses", i), 64'(g_adds), 64'(vecs[i].loads));
            check($sformatf("v%0d cycles to result", i), 64'(g_cycles), 64'(vecs[i].cycles));
            check($sformatf("v%0d nonce sequence errs", i), 64'(g_seq_err), 64'd0);
            check($sformatf("v%0d round_idx errs", i), 64'(g_idx_err), 64'd0);
            check($sformatf("v%0d enable overlap errs", i), 64'(g_excl_err), 64'd0);
            check($sformatf("v%0d per-nonce spacing errs", i), 64'(g_gap_err), 64'd0);
            @(negedge clk);
            check($sformatf("v%0d idle after done", i), {61'd0, busy, found, exhausted},
                  {61'd0, 1'b0, vecs[i].f, vecs[i].e});
        end

        // Abort in IDLE leaves a held found flag alone.
        run_job(32'h0000_0010, 32'h0000_0010, 1'b1, 32'h0000_0010, 1'b0);
        check("found before idle abort", {63'd0, found}, 64'd1);
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        check("idle abort no effect", {61'd0, busy, found, exhausted}, 64'd2);
        check("idle abort keeps nonce", {32'd0, nonce}, 64'h10);

        // Abort at round 30 of the first nonce, with a re-start held high during the job.
        nonce_start = 32'h0000_0020; nonce_end = 32'h0000_0030; start = 1'b1;
        @(negedge clk);
        nonce_start = 32'h0000_0099;
        g_timeout = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (round_en && round_idx == 6'd30) begin
                g_timeout = 1'b0;
                break;
            end
            @(negedge clk);
        end
        check("reach round 30", {63'd0, g_timeout}, 64'd0);
        abort = 1'b1; start = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy/round_en", {62'd0, busy, round_en}, 64'd0);
        check("abort load/add", {62'd0, load_en, add_en}, 64'd0);
        check("abort flags", {62'd0, found, exhausted}, 64'd0);
        check("abort round_idx", {58'd0, round_idx}, 64'd0);
        @(negedge clk);
        check("abort stays idle", {63'd0, busy}, 64'd0);
        check("ignored start nonce", {32'd0, nonce}, 64'h20);

        // Reset pulse mid-ROUNDS clears everything at once and leaves no pulse afterwards.
        nonce_start = 32'h0000_0001; nonce_end = 32'h0000_0009; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("mid-job round_en", {63'd0, round_en}, 64'd1);
        n_rst = 1'b0;
        #1;
        check("async reset enables", {61'd0, load_en, round_en, add_en}, 64'd0);
        check("async reset flags", {61'd0, busy, found, exhausted}, 64'd0);
        check("async reset nonce/idx", {26'd0, nonce, round_idx}, 64'd0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        check("post reset release", {59'd0, busy, found, exhausted, load_en, round_en}, 64'd0);

`ifdef SHA_SCHED_STATS_EN
        run_job(32'h0000_000A, 32'h0000_000D, 1'b0, 32'h0000_0000, 1'b0);
        check("stats exhausted", {63'd0, exhausted}, 64'd1);
        check("stats hash_count", {32'd0, hash_count}, 64'd4);
        @(negedge clk);
        nonce_start = 32'h0000_0001; nonce_end = 32'h0000_0002; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("stats cleared on start", {32'd0, hash_count}, 64'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
